// File: rtl/isp_dram_ctrl_if.sv
// AXI4 burst bus between the ISP DRAM controller (master) and the DRAM port (slave).
// Only the fields this controller drives or observes are carried; constant fields come from the parent.
interface isp_dram_ctrl_if;
  logic [31:0]  awaddr_s_inf;
  logic         awvalid_s_inf;
  logic         awready_s_inf;
  logic [127:0] wdata_s_inf;
  logic         wlast_s_inf;
  logic         wvalid_s_inf;
  logic         wready_s_inf;
  logic         bvalid_s_inf;
  logic         bready_s_inf;
  logic [31:0]  araddr_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [127:0] rdata_s_inf;
  logic         rlast_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;

  modport master (
    output awaddr_s_inf, awvalid_s_inf, wdata_s_inf, wlast_s_inf, wvalid_s_inf,
           bready_s_inf, araddr_s_inf, arvalid_s_inf, rready_s_inf,
    input  awready_s_inf, wready_s_inf, bvalid_s_inf, arready_s_inf,
           rdata_s_inf, rlast_s_inf, rvalid_s_inf
  );

  modport slave (
    input  awaddr_s_inf, awvalid_s_inf, wdata_s_inf, wlast_s_inf, wvalid_s_inf,
           bready_s_inf, araddr_s_inf, arvalid_s_inf, rready_s_inf,
    output awready_s_inf, wready_s_inf, bvalid_s_inf, arready_s_inf,
           rdata_s_inf, rlast_s_inf, rvalid_s_inf
  );
endinterface

// File: rtl/isp_dram_ctrl.sv
// Whole-picture AXI4 burst master: arbitrates a picture-read and a picture-write requester
// round-robin and runs one BEATS-long burst at a time on the shared AXI port.
module isp_dram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          PIC_BYTES = 3072,
  parameter int          BEATS     = 192
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rd_req,
  input  logic [3:0]     rd_pic_no,
  output logic           rd_gnt,
  output logic [127:0]   rd_data,
  output logic           rd_valid,
  output logic           rd_last,
  input  logic           wr_req,
  input  logic [3:0]     wr_pic_no,
  output logic           wr_gnt,
  input  logic [127:0]   wr_data,
  input  logic           wr_valid,
  output logic           wr_ready,
  output logic           done,
  output logic           busy,
  isp_dram_ctrl_if.master axi
);
  localparam int CW = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, AR, RD, AW, WR, B} state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          prefer_rd;
  logic [31:0]   addr;
  logic          last_beat;
  logic          w_hs;

  function automatic logic [31:0] pic_addr(input logic [3:0] pic);
    return BASE_ADDR + 32'(pic) * 32'(PIC_BYTES);
  endfunction

  // Write data path is a straight pass-through, gated so nothing leaks outside WR.
  assign last_beat         = (beat_cnt == CW'(BEATS - 1));
  assign axi.wvalid_s_inf  = (state == WR) && wr_valid;
  assign axi.wdata_s_inf   = (state == WR) ? wr_data : '0;
  assign axi.wlast_s_inf   = (state == WR) && last_beat;
  assign wr_ready          = (state == WR) && axi.wready_s_inf;
  assign w_hs              = axi.wvalid_s_inf && axi.wready_s_inf;
  assign axi.araddr_s_inf  = addr;
  assign axi.awaddr_s_inf  = addr;
  assign busy              = (state != IDLE);

  // NOTE: all state below uses <= so every branch sees the pre-edge values; a blocking
  // assignment here would create ordering-dependent behaviour between simulator and silicon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      prefer_rd         <= 1'b1;
      addr              <= '0;
      rd_gnt            <= 1'b0;
      wr_gnt            <= 1'b0;
      // NOTE: the read data register is reset too, because every output must read 0 in reset.
      rd_data           <= '0;
      rd_valid          <= 1'b0;
      rd_last           <= 1'b0;
      done              <= 1'b0;
      axi.arvalid_s_inf <= 1'b0;
      axi.rready_s_inf  <= 1'b0;
      axi.awvalid_s_inf <= 1'b0;
      axi.bready_s_inf  <= 1'b0;
    end else begin
      rd_gnt   <= 1'b0;
      wr_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_req && (prefer_rd || !wr_req)) begin
            rd_gnt    <= 1'b1;
            prefer_rd <= 1'b0;
            addr      <= pic_addr(rd_pic_no);
            state     <= AR;
          end else if (wr_req) begin
            wr_gnt    <= 1'b1;
            prefer_rd <= 1'b1;
            addr      <= pic_addr(wr_pic_no);
            state     <= AW;
          end
        end
        // The grant cycle is spent in AR/AW with valid still low, so valid follows gnt by one cycle.
        AR: begin
          if (!axi.arvalid_s_inf) begin
            axi.arvalid_s_inf <= 1'b1;
          end else if (axi.arready_s_inf) begin
            axi.arvalid_s_inf <= 1'b0;
            axi.rready_s_inf  <= 1'b1;
            state             <= RD;
          end
        end
        RD: begin
          if (axi.rvalid_s_inf) begin
            rd_data  <= axi.rdata_s_inf;
            rd_valid <= 1'b1;
            rd_last  <= axi.rlast_s_inf;
            if (axi.rlast_s_inf) begin
              axi.rready_s_inf <= 1'b0;
              done             <= 1'b1;
              state            <= IDLE;
            end
          end
        end
        AW: begin
          if (!axi.awvalid_s_inf) begin
            axi.awvalid_s_inf <= 1'b1;
          end else if (axi.awready_s_inf) begin
            axi.awvalid_s_inf <= 1'b0;
            state             <= WR;
          end
        end
        WR: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_cnt         <= '0;
              axi.bready_s_inf <= 1'b1;
              state            <= B;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        B: begin
          if (axi.bvalid_s_inf) begin
            axi.bready_s_inf <= 1'b0;
            done             <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_isp_dram_ctrl.sv
// Directed bench for isp_dram_ctrl: the bench plays both requesters and the AXI slave,
// checking addresses, beat counts, ordering, arbitration and asynchronous abort.
module tb_isp_dram_ctrl;
  localparam int BEATS = 192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_pic_no = '0;
  logic         rd_gnt;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic         wr_req = 1'b0;
  logic [3:0]   wr_pic_no = '0;
  logic         wr_gnt;
  logic [127:0] wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic         done;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  isp_dram_ctrl_if axi ();

  isp_dram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_pic_no (rd_pic_no),
    .rd_gnt    (rd_gnt),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .wr_req    (wr_req),
    .wr_pic_no (wr_pic_no),
    .wr_gnt    (wr_gnt),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .done      (done),
    .busy      (busy),
    .axi       (axi)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input logic [7:0] kind, input logic [3:0] pic, input int beat);
    return {kind, 20'h5A5A5, pic, 32'(beat), ~32'(beat), 32'h1234_0000 + 32'(beat)};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {rd_gnt, wr_gnt, rd_valid, rd_last, done, busy, wr_ready,
                          axi.awvalid_s_inf, axi.wvalid_s_inf, axi.wlast_s_inf,
                          axi.bready_s_inf, axi.arvalid_s_inf, axi.rready_s_inf}, '0);
    check({tag, "_addr"}, {axi.awaddr_s_inf, axi.araddr_s_inf}, '0);
    check({tag, "_rd_data"}, rd_data, '0);
    check({tag, "_wdata"}, axi.wdata_s_inf, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(input bit is_rd);
    int n = 0;
    tick();
    check("done_one_cycle", done, 1'b0);
    while (!(is_rd ? rd_gnt : wr_gnt) && n < 10) begin
      tick();
      n++;
    end
    check(is_rd ? "rd_gnt" : "wr_gnt", is_rd ? rd_gnt : wr_gnt, 1'b1);
    check("gnt_other", is_rd ? wr_gnt : rd_gnt, 1'b0);
    check("gnt_cycle_valid", is_rd ? axi.arvalid_s_inf : axi.awvalid_s_inf, 1'b0);
    check("gnt_busy", busy, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] pic, input logic [31:0] exp_addr,
                         input int gap_mod, input int abort_beat);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit hs;
    rd_req    = 1'b1;
    rd_pic_no = pic;
    wait_gnt(1'b1);
    rd_req = 1'b0;
    tick();
    check("rd_gnt_pulse", rd_gnt, 1'b0);
    check("arvalid", axi.arvalid_s_inf, 1'b1);
    check("araddr", axi.araddr_s_inf, exp_addr);
    repeat (2) begin
      tick();
      check("araddr_hold", {axi.arvalid_s_inf, axi.araddr_s_inf}, {1'b1, exp_addr});
    end
    axi.arready_s_inf = 1'b1;
    tick();
    axi.arready_s_inf = 1'b0;
    check("ar_done", {axi.arvalid_s_inf, axi.rready_s_inf}, 2'b01);
    while (got < BEATS && cyc < 2000) begin
      axi.rvalid_s_inf = (sent < BEATS) && (gap_mod == 0 || cyc % gap_mod != gap_mod - 1);
      axi.rdata_s_inf  = axi.rvalid_s_inf ? pat(8'h52, pic, sent) : '0;
      axi.rlast_s_inf  = axi.rvalid_s_inf && (sent == BEATS - 1);
      hs = axi.rvalid_s_inf && axi.rready_s_inf;
      if (hs) sent++;
      tick();
      cyc++;
      check("rd_valid_lat", rd_valid, hs);
      check("rd_done", done, rd_valid && got == BEATS - 1);
      if (rd_valid) begin
        check("rd_data", rd_data, pat(8'h52, pic, got));
        check("rd_last", rd_last, got == BEATS - 1);
        got++;
        if (got == BEATS) check("rd_busy_drop", busy, 1'b0);
        if (got == abort_beat) begin
          axi.rvalid_s_inf = 1'b0;
          axi.rlast_s_inf  = 1'b0;
          axi.rdata_s_inf  = '0;
          #2 rst_n = 1'b0;
          #1 check_quiet("abort");
          return;
        end
      end
    end
    axi.rvalid_s_inf = 1'b0;
    axi.rlast_s_inf  = 1'b0;
    axi.rdata_s_inf  = '0;
    check("rd_beats", got, BEATS);
  endtask

  task automatic do_write(input logic [3:0] pic, input logic [31:0] exp_addr,
                          input int aw_delay, input bit rand_rdy, input int gap_mod);
    int sent = 0;
    int cyc  = 0;
    wr_req    = 1'b1;
    wr_pic_no = pic;
    wait_gnt(1'b0);
    wr_req            = 1'b0;
    wr_valid          = 1'b1;
    wr_data           = pat(8'h57, pic, 0);
    axi.wready_s_inf  = 1'b1;
    tick();
    check("wr_gnt_pulse", wr_gnt, 1'b0);
    check("awvalid", axi.awvalid_s_inf, 1'b1);
    check("awaddr", axi.awaddr_s_inf, exp_addr);
    for (int d = 0; d < aw_delay; d++) begin
      #1 check("w_before_aw", {axi.wvalid_s_inf, wr_ready}, 2'b00);
      tick();
      check("awaddr_hold", {axi.awvalid_s_inf, axi.awaddr_s_inf}, {1'b1, exp_addr});
    end
    axi.awready_s_inf = 1'b1;
    #1 check("w_at_aw", axi.wvalid_s_inf, 1'b0);
    tick();
    axi.awready_s_inf = 1'b0;
    check("aw_done", axi.awvalid_s_inf, 1'b0);
    while (sent < BEATS && cyc < 3000) begin
      wr_valid         = (gap_mod == 0) || (cyc % gap_mod != 0);
      wr_data          = pat(8'h57, pic, sent);
      axi.wready_s_inf = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("wvalid", axi.wvalid_s_inf, wr_valid);
      check("wr_ready", wr_ready, axi.wready_s_inf);
      if (axi.wvalid_s_inf) begin
        check("wlast", axi.wlast_s_inf, sent == BEATS - 1);
        check("wdata", axi.wdata_s_inf, pat(8'h57, pic, sent));
        if (axi.wready_s_inf) sent++;
      end
      tick();
      cyc++;
    end
    check("w_beats", sent, BEATS);
    wr_valid          = 1'b1;
    axi.bvalid_s_inf  = 1'b0;
    #1 check("b_wait", {axi.bready_s_inf, axi.wvalid_s_inf, busy}, 3'b101);
    tick();
    axi.bvalid_s_inf = 1'b1;
    check("b_hold", {axi.bready_s_inf, done}, 2'b10);
    tick();
    axi.bvalid_s_inf = 1'b0;
    wr_valid         = 1'b0;
    check("wr_done", {done, busy, axi.bready_s_inf}, 3'b100);
  endtask

  initial begin
    axi.awready_s_inf = 1'b0;
    axi.wready_s_inf  = 1'b1;
    axi.bvalid_s_inf  = 1'b0;
    axi.arready_s_inf = 1'b1;
    axi.rdata_s_inf   = '1;
    axi.rlast_s_inf   = 1'b1;
    axi.rvalid_s_inf  = 1'b1;
    rd_req    = 1'b1;
    wr_req    = 1'b1;
    rd_pic_no = 4'hF;
    wr_pic_no = 4'hF;
    repeat (3) tick();
    check_quiet("por");
    rd_req            = 1'b0;
    wr_req            = 1'b0;
    axi.arready_s_inf = 1'b0;
    axi.rvalid_s_inf  = 1'b0;
    axi.rlast_s_inf   = 1'b0;
    axi.rdata_s_inf   = '0;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {busy, rd_gnt, wr_gnt}, 3'b000);

    do_read(4'd0, 32'h0001_0000, 5, -1);
    do_write(4'd15, 32'h0001_B400, 2, 1'b0, 0);

    // Simultaneous requests after reset: read first, then the pending write.
    apply_reset();
    wr_req    = 1'b1;
    wr_pic_no = 4'd2;
    do_read(4'd1, 32'h0001_0C00, 0, -1);
    do_write(4'd2, 32'h0001_1800, 0, 1'b0, 0);
    // Last served was the write, so read wins again.
    wr_req    = 1'b1;
    wr_pic_no = 4'd5;
    do_read(4'd4, 32'h0001_3000, 3, -1);
    do_write(4'd5, 32'h0001_3C00, 1, 1'b0, 0);

    do_write(4'd7, 32'h0001_5400, 5, 1'b1, 3);

    do_read(4'd9, 32'h0001_6C00, 0, 100);
    repeat (2) tick();
    check_quiet("abort_hold");
    rst_n = 1'b1;
    tick();
    check_quiet("post_abort");
    do_read(4'd3, 32'h0001_2400, 4, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/isp_dram_ctrl.md
Name: isp_dram_ctrl

Overview:
AXI4 burst master that moves whole pictures between DRAM and the ISP datapath. Two requesters share one AXI port: a read requester (picture fetch) and a write requester (processed picture write-back), arbitrated round-robin, one transaction outstanding at a time. The parent drives the constant AXI fields: ID=0, size=3'b100 (16 B), burst=INCR, len=BEATS-1.

Parameters:
BASE_ADDR, 32'h0001_0000, DRAM address of picture 0
PIC_BYTES, 3072, bytes per picture (32x32x3)
BEATS, 192, 128-bit beats per picture (PIC_BYTES/16)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rd_req  in  1  read request (level)
rd_pic_no  in  4  picture to read, sampled at rd_gnt
rd_gnt  out  1  1-cycle pulse, read request accepted
rd_data  out  128  read beat to datapath
rd_valid  out  1  rd_data valid (no backpressure)
rd_last  out  1  final read beat
wr_req  in  1  write request (level)
wr_pic_no  in  4  picture to write, sampled at wr_gnt
wr_gnt  out  1  1-cycle pulse, write request accepted
wr_data  in  128  write beat from datapath
wr_valid  in  1  wr_data valid
wr_ready  out  1  wr_data consumed
done  out  1  1-cycle pulse, transaction complete
busy  out  1  state != IDLE
awaddr_s_inf  out  32  write burst address
awvalid_s_inf  out  1  AW valid
awready_s_inf  in  1  AW ready
wdata_s_inf  out  128  write data
wlast_s_inf  out  1  last write beat
wvalid_s_inf  out  1  W valid
wready_s_inf  in  1  W ready
bvalid_s_inf  in  1  write response valid (resp ignored)
bready_s_inf  out  1  B ready
araddr_s_inf  out  32  read burst address
arvalid_s_inf  out  1  AR valid
arready_s_inf  in  1  AR ready
rdata_s_inf  in  128  read data
rlast_s_inf  in  1  last read beat
rvalid_s_inf  in  1  R valid (resp ignored)
rready_s_inf  out  1  R ready

Behaviour:
- Single clock clk; reset asynchronous, active-low, on rst_n. While rst_n=0: every output 0, state IDLE, beat counter 0, round-robin pointer = read-first. Reset mid-transaction aborts immediately; no resume.
- States: IDLE, AR, RD, AW, WR, B.
- IDLE: one request -> grant it. Both requests -> grant the type not served last (read after reset). Grant: gnt pulse, pic_no latched, address = BASE_ADDR + pic_no*PIC_BYTES registered; next cycle AR (read) or AW (write). Requests are ignored outside IDLE; requester drops req after gnt.
- AR: arvalid=1, araddr stable until arvalid&&arready -> RD.
- RD: rready=1. Each rvalid beat registered to rd_data/rd_valid (latency 1); rd_last = registered rlast. rlast beat -> IDLE; done pulses with rd_last.
- AW: awvalid=1, awaddr stable until handshake -> WR. wvalid never asserts before the AW handshake completes.
- WR: wvalid=wr_valid, wdata=wr_data, wr_ready=wready (combinational pass-through). Beat counter 0..BEATS-1 increments on wvalid&&wready. wlast=(counter==BEATS-1). Last beat -> B; counter cleared.
- B: bready=1; bvalid -> IDLE, done pulses next cycle.
- A new grant is allowed in the same cycle the done pulse is high.
- Address arithmetic is 32-bit unsigned. Maximum is pic 15 -> 0x0001_B400. No overflow possible.

Test Plan:
- Reset, rd_req pic 0 -> rd_gnt, next cycle arvalid with araddr 0x0001_0000. Slave returns 192 beats -> 192 rd_valid pulses, each 1 cycle after rvalid, rd_last and done on beat 192, busy drops after.
- wr_req pic 15 -> awaddr 0x0001_B400. No wvalid until awready. wlast exactly on beat 192. done 1 cycle after bvalid.
- After reset, rd_req and wr_req rise the same cycle and stay high until granted -> read granted first, write granted in the IDLE after the read's done. Repeat with both requests again -> read granted first (last served was the write).
- Write backpressure: awready delayed 5 cycles, wready 50% random, wr_valid gaps -> awaddr stable, exactly 192 W handshakes, wlast only on the 192nd, data order preserved.
- rst_n low during read beat 100 -> all outputs 0 asynchronously. After release, rd_req pic 3 -> araddr 0x0001_2400, full 192-beat read.
